mem_stage_lsu: RTL and testbench

//  MEM stage of the 5-stage RV32I pipeline, directly downstream of EX. Takes EX/MEM-registered ALU result,

---
 rtl/pipeline_pkg.sv | 24 ++
 rtl/lsu_fmt.sv | 63 ++++++
 rtl/mem_stage_lsu.sv | 140 ++++++++++++++
 tb/tb_mem_stage_lsu.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared constants and types for the MEM-stage load/store unit.
// Holds opcode and funct3 encodings, exception codes and the LSU FSM state type.
package pipeline_pkg;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] EXC_NONE     = 2'b00;
   localparam logic [1:0] EXC_MISALIGN = 2'b01;
   localparam logic [1:0] EXC_TIMEOUT  = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      DONE = 2'b10
   } lsu_state_e;

endpackage

// File: rtl/lsu_fmt.sv
// Combinational data formatting for the LSU: store lane replication and byte
// enables, load lane extraction with sign/zero extension, and misalignment detection.
module lsu_fmt
   import pipeline_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr,
   input  logic        i_is_store,
   input  logic [31:0] i_rs2,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_ld_data,
   output logic        o_misaligned
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // funct3[1:0] carries the access size; 11 falls into the word case.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      o_be         = 4'b1111;
      o_wdata      = i_rs2;
      o_misaligned = 1'b0;
      case (i_funct3[1:0])
         2'b00: begin
            if (i_is_store) begin
               o_be    = 4'b0001 << i_addr;
               o_wdata = {4{i_rs2[7:0]}};
            end
         end
         2'b01: begin
            o_misaligned = i_addr[0];
            if (i_is_store) begin
               o_be    = 4'b0011 << {i_addr[1], 1'b0};
               o_wdata = {2{i_rs2[15:0]}};
            end
         end
         default: o_misaligned = |i_addr;
      endcase
   end

   always_comb begin
      case (i_addr)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

      case (i_funct3)
         F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
         F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
         F3_BU:   o_ld_data = {24'd0, w_byte};
         F3_HU:   o_ld_data = {16'd0, w_half};
         F3_W:    o_ld_data = i_rdata;
         default: o_ld_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage of the RV32I pipeline: runs loads/stores on a req/ack bus with a
// timeout, stalls upstream while busy, and owns the MEM/WB pipeline register.
module mem_stage_lsu
   import pipeline_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   input  logic [31:0] i_instr_MEM,
   input  logic [31:0] i_alu_data,
   input  logic [31:0] i_rs2_data,
   input  logic [31:0] i_pc_plus4,
   output logic [31:0] alu_out_mem,
   output logic [31:0] pc_plus4_mem,
   output logic        o_stall,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   output logic [31:0] o_dmem_addr,
   output logic [3:0]  o_dmem_be,
   output logic [31:0] o_dmem_wdata,
   input  logic        i_dmem_ack,
   input  logic [31:0] i_dmem_rdata,
   output logic        o_wb_valid,
   output logic [31:0] o_wb_instr,
   output logic [31:0] o_wb_alu,
   output logic [31:0] o_wb_ld,
   output logic [31:0] o_wb_pc4,
   output logic [1:0]  o_wb_exc
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   lsu_state_e  r_state;
   lsu_state_e  w_next_state;
   logic [7:0]  r_cnt;
   logic [31:0] r_ld_buf;
   logic [1:0]  r_exc_buf;

   logic [6:0]  w_opcode;
   logic        w_is_store;
   logic        w_mem_op;
   logic        w_misaligned;
   logic        w_timeout;
   logic [31:0] w_ld_fmt;
   logic [1:0]  w_wb_exc;

   assign w_opcode   = i_instr_MEM[6:0];
   assign w_is_store = (w_opcode == OPC_STORE);
   assign w_mem_op   = i_valid & ((w_opcode == OPC_LOAD) | w_is_store);
   assign w_timeout  = (r_cnt == CNT_LAST);

   assign alu_out_mem  = i_alu_data;
   assign pc_plus4_mem = i_pc_plus4;
   assign o_dmem_addr  = {i_alu_data[31:2], 2'b00};
   assign o_dmem_we    = w_is_store;

   lsu_fmt u_fmt (
      .i_funct3     (i_instr_MEM[14:12]),
      .i_addr       (i_alu_data[1:0]),
      .i_is_store   (w_is_store),
      .i_rs2        (i_rs2_data),
      .i_rdata      (i_dmem_rdata),
      .o_be         (o_dmem_be),
      .o_wdata      (o_dmem_wdata),
      .o_ld_data    (w_ld_fmt),
      .o_misaligned (w_misaligned)
   );

   always_comb begin
      w_next_state = r_state;
      o_stall      = 1'b0;
      o_dmem_req   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_mem_op && !w_misaligned) begin
               w_next_state = REQ;
               o_stall      = 1'b1;
            end
         end
         REQ: begin
            o_dmem_req = 1'b1;
            o_stall    = 1'b1;
            if (i_dmem_ack || w_timeout) w_next_state = DONE;
         end
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // NOTE: sequential state is written only with non-blocking assignments so
   // every register samples the pre-edge values of its neighbours.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= IDLE;
         r_cnt     <= 8'd0;
         r_ld_buf  <= 32'd0;
         r_exc_buf <= EXC_NONE;
      end else begin
         r_state <= w_next_state;
         if (r_state == REQ && w_next_state == REQ) r_cnt <= r_cnt + 8'd1;
         else                                       r_cnt <= 8'd0;
         // An ack always wins over a timeout landing on the same cycle.
         if (r_state == REQ) begin
            if (i_dmem_ack) begin
               r_ld_buf  <= w_ld_fmt;
               r_exc_buf <= EXC_NONE;
            end else if (w_timeout) begin
               r_exc_buf <= EXC_TIMEOUT;
            end
         end
      end
   end

   assign w_wb_exc = (r_state == DONE)                ? r_exc_buf    :
                     (w_mem_op && w_misaligned)       ? EXC_MISALIGN :
                                                        EXC_NONE;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_wb_valid <= 1'b0;
         o_wb_instr <= 32'd0;
         o_wb_alu   <= 32'd0;
         o_wb_ld    <= 32'd0;
         o_wb_pc4   <= 32'd0;
         o_wb_exc   <= EXC_NONE;
      end else if (!o_stall) begin
         o_wb_valid <= i_valid;
         o_wb_instr <= i_instr_MEM;
         o_wb_alu   <= i_alu_data;
         o_wb_ld    <= r_ld_buf;
         o_wb_pc4   <= i_pc_plus4;
         o_wb_exc   <= w_wb_exc;
      end else begin
         o_wb_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized scoreboard bench for mem_stage_lsu: a byte-level memory model predicts
// each instruction's MEM/WB result, stall length and bus signals.
module tb_mem_stage_lsu;

   localparam int TO = 4;
   localparam logic [6:0] OPC_LD  = 7'b0000011;
   localparam logic [6:0] OPC_ST  = 7'b0100011;
   localparam logic [6:0] OPC_OP  = 7'b0110011;
   localparam logic [6:0] OPC_IMM = 7'b0010011;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] alu;
      logic [31:0] pc4;
      logic [31:0] ld;
      bit          chk_ld;
      logic [1:0]  exc;
      int          stall;
   } exp_t;

   logic        i_clk, i_rst_n, i_valid, i_dmem_ack;
   logic [31:0] i_instr_MEM, i_alu_data, i_rs2_data, i_pc_plus4, i_dmem_rdata;
   logic [31:0] alu_out_mem, pc_plus4_mem, o_dmem_addr, o_dmem_wdata;
   logic [31:0] o_wb_instr, o_wb_alu, o_wb_ld, o_wb_pc4;
   logic        o_stall, o_dmem_req, o_dmem_we, o_wb_valid;
   logic [3:0]  o_dmem_be;
   logic [1:0]  o_wb_exc;

   int n_checks = 0;
   int n_errors = 0;
   exp_t exp_q[$];
   logic [31:0] model_mem [16];
   logic [31:0] slave_mem [16];

   int          cur_delay;
   logic [31:0] cur_addr, cur_wdata;
   logic [3:0]  cur_be;
   bit          cur_we;

   mem_stage_lsu #(.TIMEOUT_CYCLES(TO)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_instr_MEM(i_instr_MEM),
      .i_alu_data(i_alu_data), .i_rs2_data(i_rs2_data), .i_pc_plus4(i_pc_plus4),
      .alu_out_mem(alu_out_mem), .pc_plus4_mem(pc_plus4_mem), .o_stall(o_stall),
      .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
      .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata), .i_dmem_ack(i_dmem_ack),
      .i_dmem_rdata(i_dmem_rdata), .o_wb_valid(o_wb_valid), .o_wb_instr(o_wb_instr),
      .o_wb_alu(o_wb_alu), .o_wb_ld(o_wb_ld), .o_wb_pc4(o_wb_pc4), .o_wb_exc(o_wb_exc)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit is_misaligned(input logic [2:0] f3, input logic [31:0] a);
      logic [1:0] lo;
      lo = a[1:0];
      if (f3[1:0] == 2'b00) return 1'b0;
      if (f3[1:0] == 2'b01) return (lo % 2) != 0;
      return lo != 0;
   endfunction

   function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a, input bit st);
      int lane;
      lane = int'(a[1:0]);
      if (!st) return 4'hF;
      if (f3 == 3'd0) return 4'(1 << lane);
      if (f3 == 3'd1) return 4'(3 << (lane - lane % 2));
      return 4'hF;
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
      if (f3 == 3'd0) return {4{d[7:0]}};
      if (f3 == 3'd1) return {2{d[15:0]}};
      return d;
   endfunction

   function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f3);
      logic [31:0] sh;
      sh = w >> (8 * int'(a[1:0]));
      case (f3)
         3'd0:    return {{24{sh[7]}}, sh[7:0]};
         3'd1:    return {{16{sh[15]}}, sh[15:0]};
         3'd4:    return {24'd0, sh[7:0]};
         3'd5:    return {16'd0, sh[15:0]};
         default: return w;
      endcase
   endfunction

   task automatic wait_accept();
      int budget;
      budget = 0;
      forever begin
         @(negedge i_clk);
         if (!o_stall) break;
         budget++;
         if (budget > 20) begin
            n_checks++;
            n_errors++;
            $display("FAIL stall_timeout: stall still %b after %0d cycles, required release", o_stall, budget);
            break;
         end
      end
   endtask

   task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rs2, input int delay);
      logic [31:0] r, instr, be_word;
      bit mem, st, mis;
      exp_t e;
      r     = $urandom();
      instr = {r[31:15], f3, r[11:7], opc};
      mem   = (opc == OPC_LD) || (opc == OPC_ST);
      st    = (opc == OPC_ST);
      mis   = mem && is_misaligned(f3, addr);
      e.instr = instr; e.alu = addr; e.pc4 = $urandom(); e.ld = 0; e.chk_ld = 0;
      e.exc = 2'b00; e.stall = 0;
      if (mis) begin
         e.exc = 2'b01;
      end else if (mem) begin
         if (delay >= TO) begin
            e.exc = 2'b10;
            e.stall = 1 + TO;
         end else begin
            e.stall = delay + 2;
            if (st) begin
               be_word = exp_wdata(f3, rs2);
               for (int b = 0; b < 4; b++)
                  if (exp_be(f3, addr, 1'b1) & (4'b1 << b))
                     model_mem[addr[5:2]][8*b +: 8] = be_word[8*b +: 8];
            end else begin
               e.ld = exp_load(model_mem[addr[5:2]], addr, f3);
               e.chk_ld = 1;
            end
         end
      end
      @(posedge i_clk); #1;
      i_valid = 1'b1; i_instr_MEM = instr; i_alu_data = addr; i_rs2_data = rs2;
      i_pc_plus4 = e.pc4;
      cur_delay = delay; cur_addr = addr; cur_we = st;
      cur_be = exp_be(f3, addr, st); cur_wdata = exp_wdata(f3, rs2);
      exp_q.push_back(e);
      wait_accept();
   endtask

   task automatic bubble();
      logic [31:0] r;
      r = $urandom();
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      i_instr_MEM = {r[31:7], (r[0] ? OPC_LD : OPC_ST)};
      i_alu_data = $urandom(); i_pc_plus4 = $urandom();
      wait_accept();
   endtask

   // Bus slave: acks after the delay chosen at issue; occasional stray acks when idle.
   initial begin
      int age;
      age = 0;
      i_dmem_ack = 1'b0;
      i_dmem_rdata = 32'd0;
      forever begin
         @(negedge i_clk);
         if (o_dmem_req) begin
            check("bus_addr", o_dmem_addr, {cur_addr[31:2], 2'b00});
            check("bus_we", {31'd0, o_dmem_we}, {31'd0, cur_we});
            check("bus_be", {28'd0, o_dmem_be}, {28'd0, cur_be});
            if (cur_we) check("bus_wdata", o_dmem_wdata, cur_wdata);
            if (age == cur_delay) begin
               i_dmem_ack = 1'b1;
               i_dmem_rdata = slave_mem[o_dmem_addr[5:2]];
               if (o_dmem_we)
                  for (int b = 0; b < 4; b++)
                     if (o_dmem_be[b]) slave_mem[o_dmem_addr[5:2]][8*b +: 8] = o_dmem_wdata[8*b +: 8];
            end else begin
               i_dmem_ack = 1'b0;
               i_dmem_rdata = $urandom();
            end
            age++;
         end else begin
            age = 0;
            i_dmem_ack = ($urandom_range(0, 5) == 0);
            i_dmem_rdata = $urandom();
         end
      end
   end

   // Monitor: forwarding paths every cycle, MEM/WB contents and stall length per retirement.
   initial begin
      int stall_run;
      exp_t e;
      stall_run = 0;
      forever begin
         @(negedge i_clk);
         if (!i_rst_n) begin
            stall_run = 0;
         end else begin
            check("fwd_alu", alu_out_mem, i_alu_data);
            check("fwd_pc4", pc_plus4_mem, i_pc_plus4);
            if (o_wb_valid) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_errors++;
                  $display("FAIL wb_unexpected: got o_wb_valid=1 instr %h, required no retirement", o_wb_instr);
               end else begin
                  e = exp_q.pop_front();
                  check("wb_instr", o_wb_instr, e.instr);
                  check("wb_alu", o_wb_alu, e.alu);
                  check("wb_pc4", o_wb_pc4, e.pc4);
                  check("wb_exc", {30'd0, o_wb_exc}, {30'd0, e.exc});
                  if (e.chk_ld) check("wb_ld", o_wb_ld, e.ld);
                  check("stall_cycles", 32'(stall_run), 32'(e.stall));
               end
               stall_run = 0;
            end
            if (o_stall) stall_run++;
         end
      end
   end

   initial begin
      int k, op, dly;
      logic [2:0] f3;
      logic [31:0] addr;
      i_rst_n = 1'b0; i_valid = 1'b0; i_instr_MEM = 0; i_alu_data = 0;
      i_rs2_data = 0; i_pc_plus4 = 0;
      cur_delay = 99; cur_addr = 0; cur_wdata = 0; cur_be = 0; cur_we = 0;
      for (int i = 0; i < 16; i++) begin
         model_mem[i] = $urandom();
         slave_mem[i] = model_mem[i];
      end
      model_mem[0] = 32'hDEADBEEF; slave_mem[0] = 32'hDEADBEEF;
      model_mem[1] = 32'h80010000; slave_mem[1] = 32'h80010000;
      #12;
      check("rst_wb_valid", {31'd0, o_wb_valid}, 32'd0);
      check("rst_req", {31'd0, o_dmem_req}, 32'd0);
      check("rst_stall", {31'd0, o_stall}, 32'd0);
      check("rst_wb_instr", o_wb_instr, 32'd0);
      check("rst_wb_ld", o_wb_ld, 32'd0);
      check("rst_wb_exc", {30'd0, o_wb_exc}, 32'd0);
      #10 i_rst_n = 1'b1;

      issue(OPC_LD, 3'd2, 32'h100, 32'h0, 1);
      issue(OPC_ST, 3'd0, 32'h103, 32'hA5, 0);
      issue(OPC_LD, 3'd0, 32'h103, 32'h0, 2);
      issue(OPC_LD, 3'd4, 32'h103, 32'h0, 0);
      issue(OPC_LD, 3'd1, 32'h101, 32'h0, 0);
      issue(OPC_LD, 3'd5, 32'h106, 32'h0, 1);
      issue(OPC_LD, 3'd2, 32'h108, 32'h0, 9);
      issue(OPC_OP, 3'd0, $urandom(), $urandom(), 0);
      issue(OPC_LD, 3'd2, 32'h10C, 32'h0, 0);
      issue(OPC_ST, 3'd2, 32'h110, $urandom(), 3);
      issue(OPC_ST, 3'd1, 32'h112, 32'h0000BEEF, 0);
      issue(OPC_LD, 3'd1, 32'h112, 32'h0, 0);

      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 4) == 0) bubble();
         op   = $urandom_range(0, 9);
         addr = 32'h100 + 32'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
         dly  = $urandom_range(0, 5);
         k    = $urandom_range(0, 7);
         f3   = 3'(k);
         if (op < 4)       issue(OPC_LD, f3, addr, $urandom(), dly);
         else if (op < 7)  issue(OPC_ST, 3'($urandom_range(0, 2)), addr, $urandom(), dly);
         else if (op < 9)  issue(OPC_OP, f3, $urandom(), $urandom(), 0);
         else              issue(OPC_IMM, f3, $urandom(), $urandom(), 0);
      end

      @(posedge i_clk); #1 i_valid = 1'b0;
      repeat (3) @(negedge i_clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      // Reset while a load is waiting on the bus.
      @(posedge i_clk); #1;
      i_valid = 1'b1; i_instr_MEM = {17'd0, 3'd2, 5'd1, OPC_LD}; i_alu_data = 32'h114;
      cur_delay = 99; cur_addr = 32'h114; cur_we = 0; cur_be = 4'hF;
      @(negedge i_clk);
      @(negedge i_clk);
      check("pre_reset_req", {31'd0, o_dmem_req}, 32'd1);
      #2 i_rst_n = 1'b0;
      #1;
      check("async_rst_req", {31'd0, o_dmem_req}, 32'd0);
      check("async_rst_wb_valid", {31'd0, o_wb_valid}, 32'd0);
      exp_q.delete();
      i_valid = 1'b0;
      @(negedge i_clk); #2 i_rst_n = 1'b1;
      repeat (5) @(negedge i_clk) begin
         check("post_rst_req", {31'd0, o_dmem_req}, 32'd0);
         check("post_rst_stall", {31'd0, o_stall}, 32'd0);
         check("post_rst_wb_valid", {31'd0, o_wb_valid}, 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
